// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Registered 4-digit result with 9999 clamp and overflow flag.
module bin2bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [3:0]   dig1,
  output logic [3:0]   dig2,
  output logic [3:0]   dig3,
  output logic [3:0]   dig4
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  s;
  logic [19:0]   b;
  logic [19:0]   b_adj;
  logic [W+19:0] sh;
  logic [4:0]    i;
  logic          ovf_pend;
  logic          last;

  always_comb begin
    b_adj = b;
    for (int k = 0; k < 5; k++) begin
      if (b[4*k +: 4] >= 4'd5)
        b_adj[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
  end

  assign sh   = {b_adj, s} << 1;
  assign last = (i == 5'(W - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Outputs move only on the final shift edge or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      b        <= '0;
      i        <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      dig1     <= '0;
      dig2     <= '0;
      dig3     <= '0;
      dig4     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            s        <= bin;
            b        <= '0;
            i        <= '0;
            ovf_pend <= (32'(bin) > 32'd9999);
          end
        end
        SHIFT: begin
          s <= sh[W-1:0];
          b <= sh[W+19:W];
          i <= i + 5'd1;
          if (last) begin
            done <= 1'b1;
            ovf  <= ovf_pend;
            if (ovf_pend) begin
              dig1 <= 4'd9;
              dig2 <= 4'd9;
              dig3 <= 4'd9;
              dig4 <= 4'd9;
            end else begin
              dig1 <= sh[W+15:W+12];
              dig2 <= sh[W+11:W+8];
              dig3 <= sh[W+7:W+4];
              dig4 <= sh[W+3:W];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
